// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared constants, FSM encoding and helpers for the IF stage
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_RUN   = 2'd0,
        IF_WAIT  = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// rtl/if_skid_buffer.sv - one-entry {pc, instr} holding slot between imem response and IF/ID
module if_skid_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    // A push in the same cycle as a pop replaces the entry rather than emptying it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= 32'd0;
            instr <= 32'd0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
            pc    <= push_pc;
            instr <= push_instr;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - RV32I fetch stage: PC, single-outstanding imem fetch, IF/ID register
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        id_branch,
    input  logic [31:0] id_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr
);

    if_state_e   state;
    logic [31:0] pc;
    logic [31:0] inflight_pc;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    logic redirect;
    logic resp;
    logic writable;

    assign redirect  = id_branch & if_id_valid;
    assign resp      = (state == IF_WAIT) & imem_rvalid & ~redirect;
    assign writable  = ~if_id_valid | ~id_stall;
    // Gating with rst_n keeps the request low for the whole reset window.
    assign imem_req  = rst_n & (state == IF_RUN) & ~redirect & ~skid_valid;
    assign imem_addr = pc;

    if_skid_buffer u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (resp & (~writable | skid_valid)),
        .pop        (writable & skid_valid),
        .flush      (redirect),
        .push_pc    (inflight_pc),
        .push_instr (imem_rdata),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IF_RUN;
            pc          <= RESET_PC;
            inflight_pc <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'd0;
            if_id_instr <= NOP_INSTR;
        end else if (redirect) begin
            pc          <= word_align(id_target);
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            // An outstanding response must still be absorbed before the next fetch.
            case (state)
                IF_WAIT, IF_DRAIN: state <= imem_rvalid ? IF_RUN : IF_DRAIN;
                default:           state <= IF_RUN;
            endcase
        end else begin
            case (state)
                IF_RUN: begin
                    if (imem_req && imem_gnt) begin
                        inflight_pc <= pc;
                        pc          <= pc + 32'd4;
                        state       <= IF_WAIT;
                    end
                end
                IF_WAIT, IF_DRAIN: begin
                    if (imem_rvalid) state <= IF_RUN;
                end
                default: state <= IF_RUN;
            endcase

            if (writable) begin
                if (skid_valid) begin
                    if_id_valid <= 1'b1;
                    if_id_pc    <= skid_pc;
                    if_id_instr <= skid_instr;
                end else if (resp) begin
                    if_id_valid <= 1'b1;
                    if_id_pc    <= inflight_pc;
                    if_id_instr <= imem_rdata;
                end else begin
                    if_id_valid <= 1'b0;
                    if_id_instr <= NOP_INSTR;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit with a memory model and stream scoreboard
module tb_if_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        id_branch;
    logic [31:0] id_target;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .id_branch   (id_branch),
        .id_target   (id_target),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_consumed = 0;
    int pend_cnt = 0;
    int mem_lat = 1;
    logic [31:0] pend_addr = 32'd0;
    logic [31:0] exp_pc = 32'd0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic        o_req, o_valid, o_hs;
    logic [31:0] o_addr, o_pc, o_instr;
    logic [31:0] hs_addr[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, sample at negedge, update memory model and the in-order stream model.
    task automatic run_cycle(input logic stall, input logic br, input logic [31:0] tgt, input logic gnt);
        id_stall    = stall;
        id_branch   = br;
        id_target   = tgt;
        imem_gnt    = gnt;
        imem_rvalid = (pend_cnt == 1);
        imem_rdata  = imem_rvalid ? (pend_addr ^ KEY) : $urandom;
        @(negedge clk);
        o_req   = imem_req;
        o_addr  = imem_addr;
        o_valid = if_id_valid;
        o_pc    = if_id_pc;
        o_instr = if_id_instr;
        o_hs    = imem_req & imem_gnt;
        if (o_valid && (!stall || br)) begin
            check("sb_pc", o_pc, exp_pc);
            check("sb_instr", o_instr, exp_pc ^ KEY);
            n_consumed++;
            exp_pc = br ? (tgt & ~32'h3) : exp_pc + 32'd4;
        end
        if (prev_wait && !(br && o_valid)) begin
            check_bit("req_hold", o_req, 1'b1);
            check("addr_hold", o_addr, prev_addr);
        end
        prev_wait = o_req & ~gnt;
        prev_addr = o_addr;
        if (imem_rvalid) pend_cnt = 0;
        else if (pend_cnt > 1) pend_cnt--;
        if (o_hs) begin
            check("one_outstanding", 32'(pend_cnt), 32'd0);
            check("addr_align", {30'd0, o_addr[1:0]}, 32'd0);
            pend_addr = o_addr;
            pend_cnt  = mem_lat;
            hs_addr.push_back(o_addr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_release();
        id_stall = 1'b0; id_branch = 1'b0; id_target = 32'd0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        pend_cnt = 0; exp_pc = 32'd0; prev_wait = 1'b0; mem_lat = 1;
        hs_addr.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        id_stall = 1'b0; id_branch = 1'b0; id_target = 32'd0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        @(negedge clk);
        check_bit("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 32'd0);
        check_bit("rst_valid", if_id_valid, 1'b0);
        check("rst_pc", if_id_pc, 32'd0);
        check("rst_instr", if_id_instr, NOP);
        reset_release();

        // Free run, then stall holding pc=8
        run_cycle(0, 0, 0, 1);
        check_bit("first_req", o_req, 1'b1);
        check("first_addr", o_addr, 32'h0);
        repeat (5) run_cycle(0, 0, 0, 1);
        check("hs_count", 32'(hs_addr.size()), 32'd3);
        check("hs_addr0", hs_addr[0], 32'h0);
        check("hs_addr1", hs_addr[1], 32'h4);
        check("hs_addr2", hs_addr[2], 32'h8);
        for (int i = 0; i < 5; i++) begin
            run_cycle(1, 0, 0, 1);
            check_bit("stall_valid", o_valid, 1'b1);
            check("stall_pc", o_pc, 32'h8);
            if (i >= 2) check_bit("stall_noreq", o_req, 1'b0);
        end
        run_cycle(0, 0, 0, 1);
        check("release_pc8", o_pc, 32'h8);
        mem_lat = 3;
        run_cycle(1, 0, 0, 1);
        check_bit("skid_out_valid", o_valid, 1'b1);
        check("skid_out_pc", o_pc, 32'hC);
        check_bit("after_skid_req", o_req, 1'b1);
        check("after_skid_addr", o_addr, 32'h10);

        // Redirect while WAIT; the late response must be dropped
        run_cycle(1, 1, 32'h103, 1);
        check_bit("redir_noreq", o_req, 1'b0);
        mem_lat = 1;
        run_cycle(0, 0, 0, 1);
        check_bit("drain_valid", o_valid, 1'b0);
        check("drain_instr", o_instr, NOP);
        check_bit("drain_noreq", o_req, 1'b0);
        run_cycle(0, 0, 0, 1);
        check_bit("drain_noreq2", o_req, 1'b0);
        run_cycle(0, 0, 0, 1);
        check_bit("target_req", o_req, 1'b1);
        check("target_addr", o_addr, 32'h100);
        check_bit("late_dropped", o_valid, 1'b0);
        run_cycle(0, 0, 0, 1);
        run_cycle(1, 0, 0, 1);
        check("target_pc", o_pc, 32'h100);

        // Redirect coincident with rvalid under stall
        run_cycle(1, 1, 32'h100, 1);
        run_cycle(0, 0, 0, 1);
        check_bit("coinc_valid", o_valid, 1'b0);
        check("coinc_instr", o_instr, NOP);
        check("coinc_addr", o_addr, 32'h100);
        run_cycle(0, 0, 0, 1);
        run_cycle(1, 0, 0, 1);
        check("coinc_pc", o_pc, 32'h100);
        run_cycle(1, 0, 0, 1);
        run_cycle(1, 1, 32'h200, 1);

        // gnt low for 4 cycles after a skid flush
        for (int i = 0; i < 4; i++) begin
            run_cycle(0, 0, 0, 0);
            check_bit("nognt_req", o_req, 1'b1);
            check("nognt_addr", o_addr, 32'h200);
        end
        run_cycle(0, 0, 0, 1);
        run_cycle(0, 0, 0, 1);
        run_cycle(0, 0, 0, 1);
        check("after_gnt_pc", o_pc, 32'h200);

        // Random traffic against the stream model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
            mem_lat = $urandom_range(1, 3);
            run_cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, t,
                      $urandom_range(0, 9) < 7);
        end
        check_bit("progress", n_consumed > 200, 1'b1);

        // Asynchronous reset mid-WAIT with IF/ID valid
        rst_n = 1'b0;
        reset_release();
        run_cycle(0, 0, 0, 1);
        run_cycle(0, 0, 0, 1);
        run_cycle(1, 0, 0, 1);
        #2;
        check_bit("pre_areset_valid", if_id_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("areset_req", imem_req, 1'b0);
        check("areset_addr", imem_addr, 32'h0);
        check_bit("areset_valid", if_id_valid, 1'b0);
        check("areset_instr", if_id_instr, NOP);
        reset_release();
        run_cycle(0, 0, 0, 1);
        check("restart_addr", o_addr, 32'h0);
        run_cycle(0, 0, 0, 1);
        run_cycle(0, 1, 32'hFFFF_FFFF, 1);
        run_cycle(0, 0, 0, 1);
        check("top_addr", o_addr, 32'hFFFF_FFFC);
        run_cycle(0, 0, 0, 1);
        run_cycle(0, 0, 0, 1);
        check("wrap_addr", o_addr, 32'h0);
        check_bit("wrap_req", o_req, 1'b1);
        run_cycle(0, 0, 0, 1);
        run_cycle(0, 0, 0, 1);
        check("wrap_pc", o_pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
